usonic_multi_sampler: RTL and testbench

- Parametrised successor to the single-channel ultrasonic front end: one block generates the transmit burst and schedules sampling across NCH ADC SPI masters.
- Sampling runs round-robin across the channels. Each FIN rising edge produces one FIFO write carrying the sample and a channel tag.
- Overflow is handled as a sticky condition that software can clear, instead of a permanent stop.
- Sits between the SPI_MASTER_ADC instances and the shared sample FIFO, clocked by CLK_FAST.

---
 rtl/usonic_multi_sampler.sv | 177 +++++++++++++++++
 tb/tb_usonic_multi_sampler.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/usonic_multi_sampler.sv
// Ultrasonic transmit burst generator plus round-robin multi-channel ADC sample scheduler.
// Optional feature macro: USONIC_SIGNED_OUT_EN (offset-binary to two's complement on WR_DATA).
module usonic_multi_sampler #(
   parameter int unsigned NCH           = 5,
   parameter int unsigned DW            = 16,
   parameter int unsigned CHW           = 3,
   parameter int unsigned TXDIV         = 1024,
   parameter int unsigned BURST_PULSES  = 32,
   parameter int unsigned BURST_PERIODS = 575,
   parameter int unsigned SAMPLE_DIV    = 256
) (
   input  logic              SYS_CLK,
   input  logic              RSTbar,
   input  logic              ON,
   output logic              TX_P,
   output logic              TX_N,
   output logic              BURST_START,
   output logic [NCH-1:0]    ADC_ENA,
   input  logic [NCH-1:0]    ADC_FIN,
   input  logic [NCH*DW-1:0] ADC_DATA,
   output logic              WR_REQ,
   output logic [DW-1:0]     WR_DATA,
   output logic [CHW-1:0]    WR_CH,
   input  logic              FIFO_FULL,
   input  logic              OVF_CLR,
   output logic              OVERFLOW
);

   localparam int unsigned TXW = (TXDIV > 1) ? $clog2(TXDIV) : 1;
   localparam int unsigned PW  = (BURST_PERIODS > 1) ? $clog2(BURST_PERIODS) : 1;
   localparam int unsigned SW  = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;

   typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_HALT} state_t;

   state_t           state_q, state_d;
   logic [TXW-1:0]   tx_cnt_q, tx_cnt_d;
   logic [PW-1:0]    period_cnt_q, period_cnt_d;
   logic [SW-1:0]    slot_cnt_q, slot_cnt_d;
   logic [CHW-1:0]   ch_q, ch_d;
   logic [NCH-1:0]   fin_prev_q;
   logic             tx_p_d, tx_n_d, burst_start_d, wr_req_d, overflow_d;
   logic [NCH-1:0]   adc_ena_d;
   logic [DW-1:0]    wr_data_d;
   logic [CHW-1:0]   wr_ch_d;
   logic             phase;
   logic [NCH-1:0]   ch_mask;
   logic             cap_edge;
   logic [DW-1:0]    sel_data;

   // Transmit counters and drive legs
   always_comb begin
      tx_cnt_d      = '0;
      period_cnt_d  = '0;
      tx_p_d        = 1'b0;
      tx_n_d        = 1'b0;
      burst_start_d = 1'b0;
      phase         = (tx_cnt_q >= TXW'(TXDIV / 2));
      if (ON) begin
         tx_p_d        = phase && (period_cnt_q < PW'(BURST_PULSES));
         tx_n_d        = !tx_p_d;
         burst_start_d = (tx_cnt_q == '0) && (period_cnt_q == '0);
         if (tx_cnt_q == TXW'(TXDIV - 1)) begin
            tx_cnt_d     = '0;
            period_cnt_d = (period_cnt_q == PW'(BURST_PERIODS - 1)) ? '0 : period_cnt_q + PW'(1);
         end else begin
            tx_cnt_d     = tx_cnt_q + TXW'(1);
            period_cnt_d = period_cnt_q;
         end
      end
   end

   // Only the channel currently scheduled can produce a capture edge
   always_comb begin
      ch_mask  = NCH'(1) << ch_q;
      cap_edge = (state_q == ST_RUN) && (|(ADC_FIN & ~fin_prev_q & ch_mask));
      sel_data = '0;
      for (int unsigned k = 0; k < NCH; k++) begin
         if (CHW'(k) == ch_q) sel_data = ADC_DATA[k*DW +: DW];
      end
   end

   // Scheduler FSM, capture and sticky overflow
   always_comb begin
      state_d    = state_q;
      slot_cnt_d = slot_cnt_q;
      ch_d       = ch_q;
      adc_ena_d  = '0;
      wr_req_d   = 1'b0;
      wr_data_d  = WR_DATA;
      wr_ch_d    = WR_CH;
      overflow_d = OVERFLOW;
      if (!ON) begin
         state_d    = ST_IDLE;
         slot_cnt_d = '0;
         ch_d       = '0;
         wr_data_d  = '0;
         wr_ch_d    = '0;
         overflow_d = 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               state_d    = ST_RUN;
               slot_cnt_d = '0;
               ch_d       = '0;
            end
            ST_RUN: begin
               if (cap_edge && FIFO_FULL) begin
                  overflow_d = 1'b1;
                  state_d    = ST_HALT;
               end else begin
                  adc_ena_d = (slot_cnt_q < SW'(SAMPLE_DIV / 2)) ? ch_mask : '0;
                  if (cap_edge) begin
                     wr_req_d = 1'b1;
`ifdef USONIC_SIGNED_OUT_EN
                     wr_data_d = {~sel_data[DW-1], sel_data[DW-2:0]};
`else
                     wr_data_d = sel_data;
`endif
                     wr_ch_d  = ch_q;
                  end
                  if (OVF_CLR) overflow_d = 1'b0;
                  if (slot_cnt_q == SW'(SAMPLE_DIV - 1)) begin
                     slot_cnt_d = '0;
                     ch_d       = (ch_q == CHW'(NCH - 1)) ? '0 : ch_q + CHW'(1);
                  end else begin
                     slot_cnt_d = slot_cnt_q + SW'(1);
                  end
               end
            end
            ST_HALT: begin
               if (OVF_CLR) begin
                  overflow_d = 1'b0;
                  state_d    = ST_RUN;
                  slot_cnt_d = '0;
                  ch_d       = '0;
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge SYS_CLK or negedge RSTbar) begin
      if (!RSTbar) begin
         state_q      <= ST_IDLE;
         tx_cnt_q     <= '0;
         period_cnt_q <= '0;
         slot_cnt_q   <= '0;
         ch_q         <= '0;
         fin_prev_q   <= '0;
         TX_P         <= 1'b0;
         TX_N         <= 1'b0;
         BURST_START  <= 1'b0;
         ADC_ENA      <= '0;
         WR_REQ       <= 1'b0;
         WR_DATA      <= '0;
         WR_CH        <= '0;
         OVERFLOW     <= 1'b0;
      end else begin
         state_q      <= state_d;
         tx_cnt_q     <= tx_cnt_d;
         period_cnt_q <= period_cnt_d;
         slot_cnt_q   <= slot_cnt_d;
         ch_q         <= ch_d;
         fin_prev_q   <= ADC_FIN;
         TX_P         <= tx_p_d;
         TX_N         <= tx_n_d;
         BURST_START  <= burst_start_d;
         ADC_ENA      <= adc_ena_d;
         WR_REQ       <= wr_req_d;
         WR_DATA      <= wr_data_d;
         WR_CH        <= wr_ch_d;
         OVERFLOW     <= overflow_d;
      end
   end

endmodule

// File: tb/tb_usonic_multi_sampler.sv
// Directed bench for usonic_multi_sampler with small counters (NCH=3, TXDIV=8, SAMPLE_DIV=8).
module tb_usonic_multi_sampler;

   localparam int unsigned NCH = 3;
   localparam int unsigned DW  = 16;
   localparam int unsigned CHW = 3;

   logic              clk;
   logic              rst_n;
   logic              on;
   logic              tx_p, tx_n, burst_start;
   logic [NCH-1:0]    adc_ena;
   logic [NCH-1:0]    adc_fin;
   logic [NCH*DW-1:0] adc_data;
   logic              wr_req;
   logic [DW-1:0]     wr_data;
   logic [CHW-1:0]    wr_ch;
   logic              fifo_full;
   logic              ovf_clr;
   logic              overflow;

   int n_assert = 0;
   int n_fail   = 0;

`ifdef USONIC_SIGNED_OUT_EN
   localparam logic [DW-1:0] EXP_WDATA = 16'h0123;
`else
   localparam logic [DW-1:0] EXP_WDATA = 16'h8123;
`endif

   usonic_multi_sampler #(
      .NCH(NCH), .DW(DW), .CHW(CHW), .TXDIV(8), .BURST_PULSES(2),
      .BURST_PERIODS(5), .SAMPLE_DIV(8)
   ) dut (
      .SYS_CLK(clk), .RSTbar(rst_n), .ON(on), .TX_P(tx_p), .TX_N(tx_n),
      .BURST_START(burst_start), .ADC_ENA(adc_ena), .ADC_FIN(adc_fin),
      .ADC_DATA(adc_data), .WR_REQ(wr_req), .WR_DATA(wr_data), .WR_CH(wr_ch),
      .FIFO_FULL(fifo_full), .OVF_CLR(ovf_clr), .OVERFLOW(overflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic wait_ena(input logic [NCH-1:0] pat);
      bit found = 0;
      for (int i = 0; i < 40 && !found; i++) begin
         @(negedge clk);
         if (adc_ena === pat) found = 1;
      end
      n_assert++;
      if (!found) begin
         n_fail++;
         $display("FAIL wait_ena: got %b required %b within 40 cycles", adc_ena, pat);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b1; on = 1'b1; adc_fin = '0; adc_data = '0; fifo_full = 1'b0; ovf_clr = 1'b0;
      #3 rst_n = 1'b0;
      repeat (2) @(negedge clk);
      n_assert++;
      if ({tx_p, tx_n, burst_start, adc_ena, wr_req, wr_data, wr_ch, overflow} !== '0) begin
         n_fail++;
         $display("FAIL reset_outputs: got %0h required 0",
                  {tx_p, tx_n, burst_start, adc_ena, wr_req, wr_data, wr_ch, overflow});
      end
      rst_n = 1'b1;
   endtask

   // Frame is 40 cycles; TX_P high on frame cycles 5-8 and 13-16
   task automatic test_transmit();
      for (int k = 1; k <= 41; k++) begin
         int  p;
         logic ep, eb;
         @(negedge clk);
         p  = (k - 1) % 40 + 1;
         ep = ((p >= 5 && p <= 8) || (p >= 13 && p <= 16));
         eb = (k == 1 || k == 41);
         n_assert++;
         if (burst_start !== eb) begin
            n_fail++; $display("FAIL burst_start cycle %0d: got %b required %b", k, burst_start, eb);
         end
         n_assert++;
         if (tx_p !== ep) begin
            n_fail++; $display("FAIL tx_p cycle %0d: got %b required %b", k, tx_p, ep);
         end
         n_assert++;
         if (tx_n !== !ep) begin
            n_fail++; $display("FAIL tx_n cycle %0d: got %b required %b", k, tx_n, !ep);
         end
      end
   endtask

   // Continues from cycle 42; ENA pattern has a 24-cycle period starting at cycle 2
   task automatic test_scheduler();
      for (int k = 42; k <= 89; k++) begin
         int m;
         logic [NCH-1:0] e;
         @(negedge clk);
         m = (k - 2) % 24;
         e = (m % 8 < 4) ? NCH'(1) << (m / 8) : '0;
         n_assert++;
         if (adc_ena !== e) begin
            n_fail++; $display("FAIL adc_ena cycle %0d: got %b required %b", k, adc_ena, e);
         end
      end
   endtask

   task automatic test_capture();
      int writes = 0;
      wait_ena(3'b010);
      adc_data[1*DW +: DW] = 16'h8123;
      adc_data[0 +: DW]    = 16'h5555;
      adc_fin = 3'b011;
      @(negedge clk);
      n_assert++;
      if (wr_req !== 1'b1) begin n_fail++; $display("FAIL cap_wr_req: got %b required 1", wr_req); end
      n_assert++;
      if (wr_ch !== 3'd1) begin n_fail++; $display("FAIL cap_wr_ch: got %0d required 1", wr_ch); end
      n_assert++;
      if (wr_data !== EXP_WDATA) begin
         n_fail++; $display("FAIL cap_wr_data: got %h required %h", wr_data, EXP_WDATA);
      end
      @(negedge clk);
      n_assert++;
      if (wr_req !== 1'b0) begin n_fail++; $display("FAIL cap_single_pulse: got %b required 0", wr_req); end
      adc_fin = '0;
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         if (wr_req === 1'b1) writes++;
      end
      n_assert++;
      if (writes != 0) begin n_fail++; $display("FAIL cap_extra_writes: got %0d required 0", writes); end
      n_assert++;
      if (wr_data !== EXP_WDATA || wr_ch !== 3'd1) begin
         n_fail++; $display("FAIL cap_hold: got %h/%0d required %h/1", wr_data, wr_ch, EXP_WDATA);
      end
   endtask

   task automatic test_overflow();
      int bad = 0;
      wait_ena(3'b001);
      fifo_full = 1'b1; adc_fin = 3'b001;
      @(negedge clk);
      n_assert++;
      if (wr_req !== 1'b0) begin n_fail++; $display("FAIL ovf_no_write: got %b required 0", wr_req); end
      n_assert++;
      if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_set: got %b required 1", overflow); end
      fifo_full = 1'b0; adc_fin = '0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         adc_fin = (i >= 40 && i < 60) ? 3'b001 : 3'b000;
         if (adc_ena !== 3'b000 || wr_req !== 1'b0 || overflow !== 1'b1) bad++;
      end
      n_assert++;
      if (bad != 0) begin n_fail++; $display("FAIL ovf_halt_hold: got %0d bad cycles required 0", bad); end
      ovf_clr = 1'b1;
      @(negedge clk);
      ovf_clr = 1'b0;
      n_assert++;
      if (overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_clear: got %b required 0", overflow); end
      @(negedge clk);
      n_assert++;
      if (adc_ena !== 3'b001) begin n_fail++; $display("FAIL ovf_resume: got %b required 001", adc_ena); end
   endtask

   task automatic test_clr_collision();
      wait_ena(3'b001);
      fifo_full = 1'b1; adc_fin = 3'b001; ovf_clr = 1'b1;
      @(negedge clk);
      fifo_full = 1'b0; adc_fin = '0; ovf_clr = 1'b0;
      n_assert++;
      if (overflow !== 1'b1) begin n_fail++; $display("FAIL collision_set_wins: got %b required 1", overflow); end
      @(negedge clk);
      n_assert++;
      if (overflow !== 1'b1 || adc_ena !== 3'b000) begin
         n_fail++; $display("FAIL collision_halt: got ovf=%b ena=%b required 1/000", overflow, adc_ena);
      end
   endtask

   task automatic test_async_reset_and_on();
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      n_assert++;
      if ({tx_p, tx_n, burst_start, adc_ena, wr_req, wr_data, wr_ch, overflow} !== '0) begin
         n_fail++;
         $display("FAIL async_reset: got %0h required 0",
                  {tx_p, tx_n, burst_start, adc_ena, wr_req, wr_data, wr_ch, overflow});
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      n_assert++;
      if (burst_start !== 1'b1) begin n_fail++; $display("FAIL restart_burst: got %b required 1", burst_start); end
      wait_ena(3'b001);
      fifo_full = 1'b1; adc_fin = 3'b001;
      @(negedge clk);
      fifo_full = 1'b0; adc_fin = '0;
      n_assert++;
      if (overflow !== 1'b1) begin n_fail++; $display("FAIL on_pre_ovf: got %b required 1", overflow); end
      on = 1'b0;
      @(negedge clk);
      on = 1'b1;
      n_assert++;
      if (overflow !== 1'b0 || tx_n !== 1'b0 || adc_ena !== 3'b000 || tx_p !== 1'b0) begin
         n_fail++; $display("FAIL on_low_clear: got ovf=%b txn=%b ena=%b required 0/0/000",
                            overflow, tx_n, adc_ena);
      end
      @(negedge clk);
      n_assert++;
      if (burst_start !== 1'b1 || tx_n !== 1'b1) begin
         n_fail++; $display("FAIL on_restart: got bs=%b txn=%b required 1/1", burst_start, tx_n);
      end
   endtask

   initial begin
      test_reset();
      test_transmit();
      test_scheduler();
      test_capture();
      test_overflow();
      test_clr_collision();
      test_async_reset_and_on();
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
